// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-port controller:
// register file geometry, the hardwired zero register and FSM state encoding.
package regfile_pkg;

  localparam int NUM_REGS = 32;
  localparam logic [4:0] REG_ZERO = 5'd31;

  localparam int DEF_AW = 5;
  localparam int DEF_DW = 64;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } wb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans req upward from ptr (modulo NREQ)
// and returns the first set bit as a one-hot grant plus its index.
module rr_arbiter #(
  parameter int NREQ = 2,
  localparam int PW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   grantIdx,
  output logic            anyGrant
);

  localparam logic [PW:0] NREQ_W = (PW+1)'(NREQ);

  // Priority scan starting at ptr, wrapping at NREQ (NREQ need not be a power of two).
  always_comb begin
    logic [PW:0] pos;
    grant    = '0;
    grantIdx = '0;
    anyGrant = 1'b0;
    pos      = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = {1'b0, ptr} + (PW+1)'(k);
      if (pos >= NREQ_W) pos = pos - NREQ_W;
      if (!anyGrant && req[pos[PW-1:0]]) begin
        anyGrant               = 1'b1;
        grant[pos[PW-1:0]]     = 1'b1;
        grantIdx               = pos[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-port controller for the 32-entry register file.
// After reset, zeroes registers 0..30 (CLEAR), then shares the single write
// port among NREQ writeback requesters with round-robin arbitration (RUN).
// Writes to register 31 (constant zero) are accepted but never enabled.
// Optional macro WB_ARB_FWD_EN: forward the write on wr_* to the read ports.
//
// Handshake: req_ready[i] is combinational and is high only in RUN, only for
// the single winning requester, and only while req_valid[i] is high. A
// transfer happens on a clock edge where valid && ready; a requester that is
// not granted must hold valid, addr and data stable until it sees ready.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW   = DEF_DW,
  parameter int AW   = DEF_AW
) (
  input  logic                     clk,
  input  logic                     reset,
  // requester side
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*AW-1:0]       req_addr,
  input  logic [NREQ*DW-1:0]       req_data,
  // register file write port
  output logic                     wr_en,
  output logic [AW-1:0]            wr_addr,
  output logic [DW-1:0]            wr_data,
  // status
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     init_done,
  output wb_state_t                dbgState,
  // read ports and forwarding
  input  logic [AW-1:0]            rd_addr1,
  input  logic [AW-1:0]            rd_addr2,
  input  logic [DW-1:0]            rf_data1,
  input  logic [DW-1:0]            rf_data2,
  output logic [DW-1:0]            rd_data1,
  output logic [DW-1:0]            rd_data2
);

  localparam int PW = $clog2(NREQ);
  localparam logic [AW-1:0] ZERO_ADDR = AW'(NUM_REGS - 1);
  localparam logic [AW-1:0] LAST_CLR  = AW'(NUM_REGS - 2);

  wb_state_t       state;
  wb_state_t       nextState;
  logic [AW-1:0]   cnt;
  logic [PW-1:0]   ptr;
  logic [NREQ-1:0] grantVec;
  logic [PW-1:0]   winIdx;
  logic            anyGrant;
  logic [AW-1:0]   winAddr;
  logic [DW-1:0]   winData;

  assign dbgState = state;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req      (req_valid),
    .ptr      (ptr),
    .grant    (grantVec),
    .grantIdx (winIdx),
    .anyGrant (anyGrant)
  );

  // Select the winning requester's address and data (one-hot OR mux).
  always_comb begin
    winAddr = '0;
    winData = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grantVec[i]) begin
        winAddr = req_addr[i*AW +: AW];
        winData = req_data[i*DW +: DW];
      end
    end
  end

  // Next state and ready: no requester is accepted until the clear finishes.
  always_comb begin
    nextState = state;
    req_ready = '0;
    case (state)
      CLEAR: if (cnt == LAST_CLR) nextState = RUN;
      RUN: begin
        nextState = RUN;
        req_ready = grantVec;
      end
      default: nextState = CLEAR;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= CLEAR;
    else       state <= nextState;
  end

  // Clear counter, round-robin pointer and the registered write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      ptr       <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      grant_id  <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          wr_en    <= 1'b1;
          wr_addr  <= cnt;
          wr_data  <= '0;
          grant_id <= '0;
          cnt      <= cnt + 1'b1;
          if (cnt == LAST_CLR) init_done <= 1'b1;
        end
        RUN: begin
          if (anyGrant) begin
            wr_en    <= (winAddr != ZERO_ADDR);
            wr_addr  <= winAddr;
            wr_data  <= winData;
            grant_id <= winIdx;
            ptr      <= (winIdx == PW'(NREQ - 1)) ? '0 : winIdx + 1'b1;
          end else begin
            wr_en <= 1'b0;
          end
        end
        default: wr_en <= 1'b0;
      endcase
    end
  end

`ifdef WB_ARB_FWD_EN
  // Bypass the write being presented, whose register update lands at the next edge.
  always_comb begin
    rd_data1 = rf_data1;
    rd_data2 = rf_data2;
    if (wr_en && (wr_addr == rd_addr1) && (rd_addr1 != ZERO_ADDR)) rd_data1 = wr_data;
    if (wr_en && (wr_addr == rd_addr2) && (rd_addr2 != ZERO_ADDR)) rd_data2 = wr_data;
  end
`else
  // Plain pass-through of the register file read data.
  always_comb begin
    rd_data1 = rf_data1;
    rd_data2 = rf_data2;
  end

  logic unusedRdAddr;
  assign unusedRdAddr = ^{rd_addr1, rd_addr2};
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a behavioural 32x64 register file.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int NREQ = 2;
  localparam int DW   = 64;
  localparam int AW   = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [0:0]        grant_id;
  logic              init_done;
  wb_state_t         dbgState;
  logic [AW-1:0]     rd_addr1, rd_addr2;
  logic [DW-1:0]     rf_data1, rf_data2;
  logic [DW-1:0]     rd_data1, rd_data2;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .grant_id  (grant_id),
    .init_done (init_done),
    .dbgState  (dbgState),
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .rf_data1  (rf_data1),
    .rf_data2  (rf_data2),
    .rd_data1  (rd_data1),
    .rd_data2  (rd_data2)
  );

  // Behavioural register file: writes any address when wr_en, starts with junk in 0..30.
  logic [DW-1:0] regs [NUM_REGS];
  bit rfInit = 1'b0;
  always @(posedge clk) begin
    if (!rfInit) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= (i == NUM_REGS - 1) ? 64'h0 : 64'hDEAD;
      rfInit <= 1'b1;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end
  assign rf_data1 = regs[rd_addr1];
  assign rf_data2 = regs[rd_addr2];

`ifdef WB_ARB_FWD_EN
  localparam logic [63:0] FWD7 = 64'h77;
`else
  localparam logic [63:0] FWD7 = 64'h0;
`endif

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]         = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  // scoreboard comparison
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic g);
    chk({tag, ".wr_en"},    64'(wr_en),    64'(en));
    chk({tag, ".wr_addr"},  64'(wr_addr),  64'(a));
    chk({tag, ".wr_data"},  wr_data,       d);
    chk({tag, ".grant_id"}, 64'(grant_id), 64'(g));
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    rd_addr1  = '0;
    rd_addr2  = '0;

    // reset state
    cyc();
    cyc();
    chk_wr("reset", 1'b0, 5'd0, 64'h0, 1'b0);
    chk("reset.init_done", 64'(init_done), 64'h0);
    chk("reset.state", 64'(dbgState), 64'(CLEAR));
    chk("reset.ready", 64'(req_ready), 64'h0);

    // clear sequence: cycles 1..31 write addresses 0..30, no ready even with valids
    reset = 1'b0;
    drv(0, 1'b1, 5'd1, 64'h11);
    drv(1, 1'b1, 5'd2, 64'h22);
    for (int k = 1; k <= 31; k++) begin
      cyc();
      chk_wr($sformatf("clear%0d", k), 1'b1, 5'(k - 1), 64'h0, 1'b0);
      chk($sformatf("clear%0d.init_done", k), 64'(init_done), (k == 31) ? 64'h1 : 64'h0);
      if (k <= 30) begin
        #1;
        chk($sformatf("clear%0d.ready", k), 64'(req_ready), 64'h0);
        if (k == 30) req_valid = '0;
      end
    end
    chk("c31.state", 64'(dbgState), 64'(RUN));

    // cycle 31: first request accepted
    drv(0, 1'b1, 5'd5, 64'hA0);
    #1 chk("c31.ready", 64'(req_ready), 64'h1);
    cyc();
    chk_wr("c32", 1'b1, 5'd5, 64'hA0, 1'b0);
    drv(0, 1'b0, 5'd0, 64'h0);
    drv(1, 1'b1, 5'd3, 64'hB1);
    #1 chk("c32.ready", 64'(req_ready), 64'h2);

    // both valid, ptr=0: grants alternate 0,1,0,1 with requesters holding until ready
    cyc();
    chk_wr("c33", 1'b1, 5'd3, 64'hB1, 1'b1);
    drv(0, 1'b1, 5'd10, 64'hC0);
    drv(1, 1'b1, 5'd11, 64'hC1);
    #1 chk("c33.ready", 64'(req_ready), 64'h1);
    cyc();
    chk_wr("c34", 1'b1, 5'd10, 64'hC0, 1'b0);
    drv(0, 1'b1, 5'd12, 64'hC2);
    #1 chk("c34.ready", 64'(req_ready), 64'h2);
    cyc();
    chk_wr("c35", 1'b1, 5'd11, 64'hC1, 1'b1);
    drv(1, 1'b1, 5'd13, 64'hC3);
    #1 chk("c35.ready", 64'(req_ready), 64'h1);
    cyc();
    chk_wr("c36", 1'b1, 5'd12, 64'hC2, 1'b0);
    drv(0, 1'b0, 5'd0, 64'h0);
    #1 chk("c36.ready", 64'(req_ready), 64'h2);
    cyc();
    chk_wr("c37", 1'b1, 5'd13, 64'hC3, 1'b1);

    // write to the zero register: accepted, never enabled
    drv(1, 1'b0, 5'd0, 64'h0);
    drv(0, 1'b1, 5'd31, 64'hFF);
    #1 chk("c37.ready", 64'(req_ready), 64'h1);
    cyc();
    chk_wr("c38", 1'b0, 5'd31, 64'hFF, 1'b0);
    drv(0, 1'b0, 5'd0, 64'h0);
    drv(1, 1'b1, 5'd7, 64'h77);
    rd_addr1 = 5'd31;
    #1 chk("c38.ready", 64'(req_ready), 64'h2);
    chk("c38.rd31", rd_data1, 64'h0);

    // write to reg 7 on the port while reading it
    cyc();
    chk_wr("c39", 1'b1, 5'd7, 64'h77, 1'b1);
    drv(1, 1'b0, 5'd0, 64'h0);
    rd_addr1 = 5'd7;
    rd_addr2 = 5'd31;
    #1 chk("c39.fwd7", rd_data1, FWD7);
    chk("c39.reg31", rd_data2, 64'h0);
    rd_addr1 = 5'd31;
    #1 chk("c39.rd31", rd_data1, 64'h0);
    chk("c39.ready", 64'(req_ready), 64'h0);

    // idle cycle: nothing granted, reg 7 now holds the data
    cyc();
    chk("c40.wr_en", 64'(wr_en), 64'h0);
    chk("c40.wr_addr_hold", 64'(wr_addr), 64'd7);
    rd_addr1 = 5'd7;
    rd_addr2 = 5'd20;
    #1 chk("c40.reg7", rd_data1, 64'h77);
    chk("c40.reg20", rd_data2, 64'h0);

    // reset pulse while a write to reg 9 is pending
    drv(0, 1'b1, 5'd9, 64'h99);
    #1 chk("c40.ready", 64'(req_ready), 64'h1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("c41.wr_en", 64'(wr_en), 64'h0);
    chk("c41.init_done", 64'(init_done), 64'h0);
    chk("c41.state", 64'(dbgState), 64'(CLEAR));
    #1 chk("c41.ready", 64'(req_ready), 64'h0);
    drv(0, 1'b0, 5'd0, 64'h0);
    rd_addr2 = 5'd9;
    cyc();
    chk_wr("c42", 1'b1, 5'd0, 64'h0, 1'b0);
    #1 chk("c42.reg9", rd_data2, 64'h0);
    cyc();
    chk_wr("c43", 1'b1, 5'd1, 64'h0, 1'b0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
